bellman_relax: RTL and testbench

- Bellman-Ford relaxation stage. Sits directly upstream of the negative-cycle detector.
- Initialises the vertex matrix, then repeatedly relaxes every edge of the adjacency matrix. Each vertex word carries a distance and a predecessor.
- Asserts relax_done when finished. Top level then pulses the detector's reset to start cycle checking on the settled vertex matrix.

---
 rtl/bellman_relax_pkg.sv | 26 ++
 rtl/bellman_relax_sat_add.sv | 35 +++
 rtl/bellman_relax.sv | 153 +++++++++++++++
 tb/tb_bellman_relax.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/bellman_relax_pkg.sv
// Shared definitions for the Bellman-Ford relaxation stage and the
// negative-cycle detector that consumes its vertex matrix.
//   - default geometry (vertex count, index width, weight width)
//   - vertex word field offsets: {reserved(1)=0, pred[PRED_W], weight[WEIGHT_W]}
//   - controller state encoding
package bellman_relax_pkg;

  localparam int NODES_DEF    = 32;
  localparam int PRED_W_DEF   = 5;
  localparam int WEIGHT_W_DEF = 16;
  localparam int VERT_W_DEF   = 1 + PRED_W_DEF + WEIGHT_W_DEF;

  // Field offsets inside a vertex word (default geometry).
  localparam int WEIGHT_LSB = 0;
  localparam int PRED_LSB   = WEIGHT_W_DEF;
  localparam int RSVD_BIT   = PRED_W_DEF + WEIGHT_W_DEF;

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    EVAL  = 3'd3,
    DONE  = 3'd4
  } relax_state_t;

endpackage

// File: rtl/bellman_relax_sat_add.sv
// Saturating signed add plus strict less-than compare.
// Ports:
//   i_src_w  source vertex distance
//   i_edge_w edge weight
//   i_dst_w  current destination distance
//   o_sum    i_src_w + i_edge_w clamped to the signed WEIGHT_W range
//   o_relax  o_sum < i_dst_w (signed, strict)
module sat_add_cmp #(
  parameter int WEIGHT_W = 16
) (
  input  logic signed [WEIGHT_W-1:0] i_src_w,
  input  logic signed [WEIGHT_W-1:0] i_edge_w,
  input  logic signed [WEIGHT_W-1:0] i_dst_w,
  output logic signed [WEIGHT_W-1:0] o_sum,
  output logic                       o_relax
);

  // Overflow shows up as disagreement between the two top bits of the
  // one-bit-wider sum; the extra sign bit tells which rail to clamp to.
  function automatic logic signed [WEIGHT_W-1:0] sat_w(input logic signed [WEIGHT_W:0] x);
    if (x[WEIGHT_W] != x[WEIGHT_W-1])
      return x[WEIGHT_W] ? $signed({1'b1, {(WEIGHT_W-1){1'b0}}})
                         : $signed({1'b0, {(WEIGHT_W-1){1'b1}}});
    else
      return x[WEIGHT_W-1:0];
  endfunction

  logic signed [WEIGHT_W:0] w_full;

  assign w_full  = $signed({i_src_w[WEIGHT_W-1], i_src_w})
                 + $signed({i_edge_w[WEIGHT_W-1], i_edge_w});
  assign o_sum   = sat_w(w_full);
  assign o_relax = (o_sum < i_dst_w);

endmodule

// File: rtl/bellman_relax.sv
// Bellman-Ford relaxation stage.
// Initialises every vertex to {0, self, 0}, then sweeps all NODES x NODES
// edges per pass (3 cycles per edge: ISSUE, WAIT, EVAL) until a pass makes
// no improvement or NODES-1 passes have completed.
// Ports:
//   clk, relax_reset          clock, synchronous active-high reset
//   vertmat_q_a / _q_b        vertex RAM read data, port A (u) / port B (v)
//   adjmat_q                  signed edge weight, 0 = no edge
//   vertmat_addr_a/_addr_b    vertex RAM addresses
//   vertmat_data_b/_we_b      vertex RAM port B write
//   adjmat_row/col_addr       adjacency RAM address (i, j)
//   relax_pass                completed pass count
//   relax_changed             last completed pass wrote at least once
//   relax_done                held high from completion until reset
module bellman_relax
  import bellman_relax_pkg::*;
#(
  parameter int NODES    = NODES_DEF,
  parameter int PRED_W   = PRED_W_DEF,
  parameter int WEIGHT_W = WEIGHT_W_DEF,
  parameter int VERT_W   = 1 + PRED_W + WEIGHT_W
) (
  input  logic                clk,
  input  logic                relax_reset,
  input  logic [VERT_W-1:0]   vertmat_q_a,
  input  logic [VERT_W-1:0]   vertmat_q_b,
  input  logic [WEIGHT_W-1:0] adjmat_q,
  output logic [PRED_W-1:0]   vertmat_addr_a,
  output logic [PRED_W-1:0]   vertmat_addr_b,
  output logic [VERT_W-1:0]   vertmat_data_b,
  output logic                vertmat_we_b,
  output logic [PRED_W-1:0]   adjmat_row_addr,
  output logic [PRED_W-1:0]   adjmat_col_addr,
  output logic [PRED_W-1:0]   relax_pass,
  output logic                relax_changed,
  output logic                relax_done
);

  localparam logic [PRED_W-1:0] LAST = PRED_W'(NODES - 1);

  relax_state_t r_state, w_state_nx;

  logic [PRED_W-1:0]          r_k, r_i, r_j, r_pass;
  logic                       r_flag, r_changed, r_done;

  logic                       w_we;
  logic [PRED_W-1:0]          w_addr_b;
  logic [VERT_W-1:0]          w_data;
  logic signed [WEIGHT_W-1:0] w_src_w, w_dst_w, w_edge_w, w_sum;
  logic                       w_relax, w_edge_live, w_write_ev, w_flag_nx, w_last_edge;
  logic [PRED_W-1:0]          w_pass_inc;
  logic                       w_unused_bits;

  // Only the distance fields are needed here; pred/reserved are for the detector.
  assign w_src_w  = $signed(vertmat_q_a[WEIGHT_W-1:0]);
  assign w_dst_w  = $signed(vertmat_q_b[WEIGHT_W-1:0]);
  assign w_edge_w = $signed(adjmat_q);
  assign w_unused_bits = ^{vertmat_q_a[VERT_W-1:WEIGHT_W], vertmat_q_b[VERT_W-1:WEIGHT_W]};

  sat_add_cmp #(.WEIGHT_W(WEIGHT_W)) u_sat_add_cmp (
    .i_src_w (w_src_w),
    .i_edge_w(w_edge_w),
    .i_dst_w (w_dst_w),
    .o_sum   (w_sum),
    .o_relax (w_relax)
  );

  // Self-loops and absent edges never relax anything.
  assign w_edge_live = (r_i != r_j) && (adjmat_q != '0);
  assign w_write_ev  = (r_state == EVAL) && w_edge_live && w_relax;
  assign w_flag_nx   = r_flag | w_write_ev;
  assign w_last_edge = (r_i == LAST) && (r_j == LAST);
  assign w_pass_inc  = r_pass + PRED_W'(1);

  always_ff @(posedge clk) begin
    if (relax_reset) r_state <= INIT;
    else             r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_we       = 1'b0;
    w_addr_b   = r_j;
    w_data     = '0;
    case (r_state)
      INIT: begin
        w_addr_b = r_k;
        w_we     = 1'b1;
        w_data   = {1'b0, r_k, {WEIGHT_W{1'b0}}};
        if (r_k == LAST) w_state_nx = ISSUE;
      end
      ISSUE: w_state_nx = WAIT;
      WAIT:  w_state_nx = EVAL;
      EVAL: begin
        w_we   = w_write_ev;
        w_data = {1'b0, r_i, w_sum};
        // A quiet pass means the distances have settled; NODES-1 passes is
        // the Bellman-Ford bound, so anything still moving is a negative cycle.
        if (w_last_edge && (!w_flag_nx || (w_pass_inc == LAST)))
          w_state_nx = DONE;
        else
          w_state_nx = ISSUE;
      end
      DONE:    w_state_nx = DONE;
      default: w_state_nx = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (relax_reset) begin
      r_k       <= '0;
      r_i       <= '0;
      r_j       <= '0;
      r_pass    <= '0;
      r_flag    <= 1'b0;
      r_changed <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        INIT: r_k <= (r_k == LAST) ? '0 : r_k + PRED_W'(1);
        EVAL: begin
          if (w_write_ev) r_flag <= 1'b1;
          if (r_j == LAST) begin
            r_j <= '0;
            r_i <= (r_i == LAST) ? '0 : r_i + PRED_W'(1);
          end else begin
            r_j <= r_j + PRED_W'(1);
          end
          if (w_last_edge) begin
            r_pass    <= w_pass_inc;
            r_changed <= w_flag_nx;
            r_flag    <= 1'b0;
            if (w_state_nx == DONE) r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // RAM-facing outputs are forced quiet while reset is held so a long reset
  // never issues INIT writes.
  assign vertmat_addr_a  = relax_reset ? '0 : r_i;
  assign vertmat_addr_b  = relax_reset ? '0 : w_addr_b;
  assign vertmat_data_b  = relax_reset ? '0 : w_data;
  assign vertmat_we_b    = !relax_reset && w_we;
  assign adjmat_row_addr = relax_reset ? '0 : r_i;
  assign adjmat_col_addr = relax_reset ? '0 : r_j;
  assign relax_pass      = r_pass;
  assign relax_changed   = r_changed;
  assign relax_done      = r_done;

endmodule

// File: tb/tb_bellman_relax.sv
module tb_bellman_relax;

  localparam int N  = 4;
  localparam int PW = 2;
  localparam int WW = 16;
  localparam int VW = 1 + PW + WW;

  logic          clk, rst;
  logic [VW-1:0] q_a, q_b, data_b;
  logic [WW-1:0] adj_q;
  logic [PW-1:0] addr_a, addr_b, row, col, pass;
  logic          we_b, changed, done;

  bellman_relax #(.NODES(N), .PRED_W(PW), .WEIGHT_W(WW)) dut (
    .clk(clk), .relax_reset(rst),
    .vertmat_q_a(q_a), .vertmat_q_b(q_b), .adjmat_q(adj_q),
    .vertmat_addr_a(addr_a), .vertmat_addr_b(addr_b),
    .vertmat_data_b(data_b), .vertmat_we_b(we_b),
    .adjmat_row_addr(row), .adjmat_col_addr(col),
    .relax_pass(pass), .relax_changed(changed), .relax_done(done)
  );

  always #5 clk = ~clk;

  // Synchronous RAMs, 1-cycle read latency.
  logic [VW-1:0] vm [N];
  logic [WW-1:0] adj [N][N];
  always @(posedge clk) begin
    q_a   <= vm[addr_a];
    q_b   <= vm[addr_b];
    adj_q <= adj[row][col];
    if (we_b) vm[addr_b] <= data_b;
  end

  // Cycle index since reset release.
  int n;
  always @(posedge clk) n <= rst ? 0 : n + 1;

  typedef struct {int n; logic [PW-1:0] a; logic [VW-1:0] d;} wr_t;
  wr_t q[$];
  wr_t e_cmp;
  int  total, bad;
  int  done_n, exp_pass, exp_ch;
  int  md[N], mp[N];
  bit  active;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Reference: in-place Bellman-Ford over edges in row-major order, with the
  // write schedule expressed as cycle numbers (INIT N cycles, 3 per edge).
  task automatic build_model();
    int d[N], p[N];
    int s, pss, ch;
    q.delete();
    for (int k = 0; k < N; k++) begin
      d[k] = 0; p[k] = k;
      q.push_back('{k, PW'(k), {1'b0, PW'(k), 16'h0}});
    end
    pss = 0;
    do begin
      pss++;
      ch = 0;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          if (i != j && adj[i][j] != 0) begin
            s = d[i] + int'($signed(adj[i][j]));
            if (s > 32767)  s = 32767;
            if (s < -32768) s = -32768;
            if (s < d[j]) begin
              d[j] = s; p[j] = i; ch = 1;
              q.push_back('{N + 3*N*N*(pss-1) + 3*(i*N+j) + 2, PW'(j), {1'b0, PW'(i), WW'(s)}});
            end
          end
        end
    end while (ch != 0 && pss < N-1);
    exp_pass = pss;
    exp_ch   = ch;
    done_n   = N + 3*N*N*pss;
    for (int k = 0; k < N; k++) begin md[k] = d[k]; mp[k] = p[k]; end
  endtask

  always @(negedge clk) begin
    if (active && !rst) begin
      if (we_b) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL spurious_we cycle=%0d addr=%0d data=%0h expected no write", n, addr_b, data_b);
        end else begin
          e_cmp = q.pop_front();
          chk("wr_cycle", n, e_cmp.n);
          chk("wr_addr", 32'(addr_b), 32'(e_cmp.a));
          chk("wr_data", 32'(data_b), 32'(e_cmp.d));
        end
      end else if (q.size() > 0 && q[0].n <= n) begin
        total++; bad++;
        $display("FAIL missed_wr cycle=%0d got no write exp addr=%0d data=%0h", n, q[0].a, q[0].d);
        void'(q.pop_front());
      end
      chk("done_flag", 32'(done), (n >= done_n) ? 32'd1 : 32'd0);
    end
  end

  task automatic clear_adj();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) adj[i][j] = '0;
  endtask

  task automatic run_case(input string nm, input int mid);
    int guard;
    active = 0;
    rst = 1;
    build_model();
    repeat (3) @(posedge clk);
    #1;
    chk({nm, "_rst_we"}, 32'(we_b), 0);
    chk({nm, "_rst_addr_b"}, 32'(addr_b), 0);
    chk({nm, "_rst_pass"}, 32'(pass), 0);
    chk({nm, "_rst_done"}, 32'(done), 0);
    rst = 0;
    active = 1;
    if (mid >= 0) begin
      guard = 0;
      while (n != mid && guard < 2000) begin @(posedge clk); #1; guard++; end
      chk({nm, "_mid_reach"}, n, mid);
      #1 rst = 1;
      @(posedge clk); #1;
      chk({nm, "_mr_we"}, 32'(we_b), 0);
      chk({nm, "_mr_data_b"}, 32'(data_b), 0);
      chk({nm, "_mr_addr_a"}, 32'(addr_a), 0);
      chk({nm, "_mr_addr_b"}, 32'(addr_b), 0);
      chk({nm, "_mr_pass"}, 32'(pass), 0);
      chk({nm, "_mr_done"}, 32'(done), 0);
      repeat (3) @(posedge clk);
      #1;
      chk({nm, "_mr_hold_we"}, 32'(we_b), 0);
      build_model();
      rst = 0;
    end
    guard = 0;
    while (!done && guard < 1000) begin @(posedge clk); #1; guard++; end
    if (!done) begin
      total++; bad++;
      $display("FAIL %s_timeout got done=0 exp done=1", nm);
    end
    repeat (2) @(posedge clk);
    #1;
    chk({nm, "_pass"}, 32'(pass), exp_pass);
    chk({nm, "_changed"}, 32'(changed), exp_ch);
    chk({nm, "_wr_left"}, q.size(), 0);
    for (int k = 0; k < N; k++)
      chk({nm, "_vm"}, 32'(vm[k]), 32'({1'b0, PW'(mp[k]), WW'(md[k])}));
    active = 0;
  endtask

  initial begin
    clk = 0; rst = 1; active = 0; total = 0; bad = 0; done_n = 0;
    clear_adj();

    run_case("zero", -1);
    chk("zero_lit_pass", 32'(pass), 1);
    chk("zero_lit_changed", 32'(changed), 0);

    clear_adj(); adj[0][1] = 16'hFFFB;
    run_case("one", -1);
    chk("one_lit_v1", 32'(vm[1]), 32'h0FFFB);
    chk("one_lit_pass", 32'(pass), 2);

    clear_adj(); adj[0][1] = 16'hFFFD; adj[1][0] = 16'h0001;
    run_case("negcyc", -1);
    chk("negcyc_lit_pass", 32'(pass), 3);
    chk("negcyc_lit_changed", 32'(changed), 1);

    clear_adj(); adj[0][1] = 16'h8008; adj[1][2] = 16'hFF9C;
    run_case("sat", -1);
    chk("sat_lit_v1", 32'(vm[1]), 32'h08008);
    chk("sat_lit_v2", 32'(vm[2]), 32'h18000);

    clear_adj(); adj[2][2] = 16'hFFF9;
    run_case("self", -1);
    chk("self_lit_v2", 32'(vm[2]), 32'h20000);
    chk("self_lit_pass", 32'(pass), 1);

    // Pass-2 EVAL of edge (0,1): 4 + 48 + 3*1 + 2 = 57.
    clear_adj(); adj[0][1] = 16'hFFFD; adj[1][0] = 16'h0001;
    run_case("midrst", 57);
    chk("midrst_lit_pass", 32'(pass), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
